jk_mod_counter: RTL and testbench

- Programmable synchronous up/down modulo-N counter built from WIDTH JK flip-flop cells.
- Sits directly upstream of the JK storage stage. Per-bit excitation logic computes J/K from the current state and the control inputs, then drives one JK cell per bit.
- Serves as the standard counting/sequencing primitive for later blocks: timers, dividers, sequence generators.

---
 rtl/jk_mod_counter_pkg.sv | 23 ++
 rtl/jk_mod_counter_jk_cell.sv | 39 +++
 rtl/jk_mod_counter.sv | 95 +++++++++
 tb/tb_jk_mod_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared constants and next-state arithmetic for the JK modulo counter.
// Direction encoding and the modulo step live here so later blocks reuse them.
package jk_mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Modulo step with explicit wrap compares (no reliance on overflow).
    function automatic logic [31:0] next_count(
        input logic [31:0] cnt,
        input logic        up_dn,
        input logic [31:0] modulus
    );
        logic [31:0] nxt;
        if (up_dn == DIR_UP) begin
            nxt = (cnt == modulus - 32'd1) ? 32'd0 : cnt + 32'd1;
        end else begin
            nxt = (cnt == 32'd0) ? modulus - 32'd1 : cnt - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset.
// 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;

    // Characteristic equation of the JK cell.
    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Programmable up/down modulo counter built from WIDTH JK cells.
// Holds only the J/K excitation logic plus the wrap and load_err pulses.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [31:0]      MOD = 32'(MODULUS);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             upd;
    logic             at_end;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;

    // Count sits at the wrap point for the current direction.
    always_comb begin
        at_end = 1'b0;
        if (up_dn == DIR_UP) begin
            at_end = (count == TOP);
        end else begin
            at_end = (count == '0);
        end
    end

    assign tc = en & ~load & at_end;

    // Next value, pulse flags, and J/K drive (never J=K=1).
    always_comb begin
        next_val   = count;
        upd        = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            upd = 1'b1;
            if (32'(load_val) < MOD) begin
                next_val = load_val;
            end else begin
                next_val   = TOP;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            upd      = 1'b1;
            next_val = WIDTH'(next_count(32'(count), up_dn, MOD));
            wrap_d   = at_end;
        end
        j = upd ? next_val : '0;
        k = upd ? ~next_val : '0;
    end

    // One-cycle status pulses, lost on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap     = wrap_q;
    assign load_err = load_err_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (count[i]),
            .q_bar (count_bar[i])
        );
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: directed plan plus random traffic
// against a modular-arithmetic model.
module tb_jk_mod_counter;

    localparam int W    = 4;
    localparam int M    = 10;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic [W-1:0] count_bar;
    logic         tc;
    logic         wrap;
    logic         load_err;

    int n_checks;
    int n_err;
    int m_cnt;
    int m_wrap;
    int m_lerr;

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .count_bar (count_bar),
        .tc        (tc),
        .wrap      (wrap),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int c, input int ld,
                                      input int e, input int up,
                                      input int lv);
        if (ld != 0) return (lv < M) ? lv : M - 1;
        if (e == 0) return c;
        if (up != 0) return (c + 1) % M;
        return (c + M - 1) % M;
    endfunction

    // Reference model: modular arithmetic on an int.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_wrap = 0;
            m_lerr = 0;
        end else begin
            int old;
            old = m_cnt;
            m_cnt = model_next(old, int'(load), int'(en),
                               int'(up_dn), int'(load_val));
            m_lerr = (load && int'(load_val) >= M) ? 1 : 0;
            m_wrap = 0;
            if (!load && en) begin
                if (up_dn) m_wrap = (old + 1 >= M) ? 1 : 0;
                else       m_wrap = (old == 0) ? 1 : 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int nx;
        int upd;
        int exp_tc;
        nx  = model_next(m_cnt, int'(load), int'(en),
                         int'(up_dn), int'(load_val));
        upd = (load || en) ? 1 : 0;
        exp_tc = 0;
        if (en && !load) begin
            if (up_dn) exp_tc = (m_cnt + 1 == M) ? 1 : 0;
            else       exp_tc = (m_cnt == 0) ? 1 : 0;
        end
        chk("count", int'(count), m_cnt);
        chk("count_bar", int'(count_bar), ~m_cnt & MASK);
        chk("tc", int'(tc), exp_tc);
        chk("wrap", int'(wrap), m_wrap);
        chk("load_err", int'(load_err), m_lerr);
        chk("j", int'(dut.j), upd != 0 ? nx : 0);
        chk("k", int'(dut.k), upd != 0 ? (~nx & MASK) : 0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic ld, input logic e, input logic up,
                          input int lv);
        load     = ld;
        en       = e;
        up_dn    = up;
        load_val = W'(lv);
    endtask

    int dn_exp[4] = '{1, 0, 9, 8};
    int fl_exp[4] = '{5, 4, 5, 4};

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        set_in(1'b0, 1'b1, 1'b1, 0);
        repeat (3) step();
        chk("rst_count", int'(count), 0);
        chk("rst_count_bar", int'(count_bar), 15);
        chk("rst_wrap", int'(wrap), 0);
        rst_n = 1'b1;

        // Up count through the wrap.
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("up_seq", int'(count), i % 10);
            chk("up_wrap", int'(wrap), (i == 10) ? 1 : 0);
        end

        // Down count through the wrap.
        set_in(1'b1, 1'b0, 1'b1, 2);
        step();
        chk("dn_load", int'(count), 2);
        set_in(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dn_seq", int'(count), dn_exp[i]);
            chk("dn_wrap", int'(wrap), (i == 2) ? 1 : 0);
        end

        // Load priority and out-of-range load.
        set_in(1'b1, 1'b1, 1'b1, 5);
        step();
        chk("ld5", int'(count), 5);
        chk("ld5_wrap", int'(wrap), 0);
        set_in(1'b1, 1'b1, 1'b0, 12);
        step();
        chk("ld12", int'(count), 9);
        chk("ld12_err", int'(load_err), 1);

        // Hold.
        set_in(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", int'(count), 9);
            chk("hold_err", int'(load_err), 0);
        end

        // Direction flip every edge.
        set_in(1'b1, 1'b0, 1'b1, 4);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 0);
            step();
            chk("flip", int'(count), fl_exp[i]);
        end

        // Async reset between edges at count 7.
        set_in(1'b1, 1'b0, 1'b1, 7);
        step();
        set_in(1'b0, 1'b0, 1'b1, 0);
        #1 rst_n = 1'b0;
        #1 chk("async_rst", int'(count), 0);
        step();
        rst_n = 1'b1;

        // Async reset kills a pending wrap pulse.
        set_in(1'b1, 1'b0, 1'b1, 9);
        step();
        set_in(1'b0, 1'b1, 1'b1, 0);
        step();
        chk("pend_wrap", int'(wrap), 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_wrap_lost", int'(wrap), 0);
        step();
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(7) == 0) ? 1'b1 : 1'b0,
                   ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                   1'($urandom_range(1)),
                   int'($urandom_range(MASK)));
            if ($urandom_range(63) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
